// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch sequencer: FSM states and PC defaults.
package mips_fetch_pkg;
  typedef enum logic [1:0] {
    INIT    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam int          PC_STEP_DEF      = 4;
endpackage

// File: rtl/fetch_ir.sv
// Instruction register plus valid bit; load captures a word, clear drops valid, otherwise hold.
module fetch_ir (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives PC loads, imem request/ack, and a valid/ready port to decode.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets set sticky fetch_err instead of loading.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          PC_STEP      = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_ld,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_count,
  output logic        fetch_err
);
  fetch_state_t state, state_nxt;
  logic         ir_load, ir_clear, ir_valid, cnt_inc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         err_set;
`endif

  assign imem_addr = pc_cur;

  fetch_ir u_ir (
    .clk   (clk),
    .rst   (rst),
    .load  (ir_load),
    .clear (ir_clear),
    .d     (imem_rdata),
    .q     (instr),
    .valid (ir_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_inc) instr_count <= instr_count + 32'd1;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)          fetch_err <= 1'b0;
    else if (err_set) fetch_err <= 1'b1;
  end
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    pc_ld       = 1'b0;
    pc_next     = pc_cur;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    ir_load     = 1'b0;
    ir_clear    = 1'b0;
    cnt_inc     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    err_set     = 1'b0;
`endif
    // Reset behaves as INIT regardless of the stored state so the PC reloads every reset cycle.
    if (rst || state == INIT) begin
      pc_ld     = 1'b1;
      pc_next   = RESET_VECTOR;
      state_nxt = REQ;
    end else if (branch_taken) begin
      ir_clear  = 1'b1;
      state_nxt = REQ;
`ifdef FETCH_ALIGN_CHECK_EN
      if (branch_target[1:0] != 2'b00) begin
        err_set = 1'b1;
      end else begin
        pc_ld   = 1'b1;
        pc_next = branch_target;
      end
`else
      pc_ld   = 1'b1;
      pc_next = branch_target;
`endif
    end else if (state == REQ) begin
      imem_req = 1'b1;
      if (imem_ack) begin
        ir_load   = 1'b1;
        state_nxt = DELIVER;
      end
    end else if (state == DELIVER) begin
      instr_valid = ir_valid;
      if (instr_ready) begin
        pc_ld     = 1'b1;
        pc_next   = pc_cur + 32'(PC_STEP);
        cnt_inc   = 1'b1;
        ir_clear  = 1'b1;
        state_nxt = REQ;
      end
    end else begin
      state_nxt = INIT;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a falling-edge PC register model and scripted imem/decode.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur = '0;
  logic [31:0] pc_next;
  logic        pc_ld;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_count;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_cur        (pc_cur),
    .pc_next       (pc_next),
    .pc_ld         (pc_ld),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_count   (instr_count),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  // PC register captures on the falling edge
  always @(negedge clk) if (pc_ld === 1'b1) pc_cur <= pc_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // inputs change 1 after the rising edge, checks run 3 after it (before the falling edge)
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    nxt(); nxt(); settle();
    chk("rst_pc_ld", 32'(pc_ld), 32'd1);
    chk("rst_pc_next", pc_next, 32'h0040_0000);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);

    // cycle rst falls: still INIT
    nxt(); rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2008_0005; instr_ready = 1'b1; settle();
    chk("init_req", 32'(imem_req), 32'd0);
    nxt(); settle();
    chk("req0", 32'(imem_req), 32'd1);
    chk("req0_addr", imem_addr, 32'h0040_0000);
    chk("req0_pcld", 32'(pc_ld), 32'd0);
    chk("req0_valid", 32'(instr_valid), 32'd0);
    nxt(); imem_ack = 1'b0; settle();
    chk("dlv0_valid", 32'(instr_valid), 32'd1);
    chk("dlv0_instr", instr, 32'h2008_0005);
    chk("dlv0_pc_next", pc_next, 32'h0040_0004);
    chk("dlv0_pcld", 32'(pc_ld), 32'd1);

    // ack delayed 3 cycles: request held 4 cycles
    for (int i = 0; i < 3; i++) begin
      nxt(); settle();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'h0040_0004);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    chk("count1", instr_count, 32'd1);
    nxt(); imem_ack = 1'b1; imem_rdata = 32'h8C09_0010; instr_ready = 1'b0; settle();
    chk("ack_req", 32'(imem_req), 32'd1);
    chk("ack_addr", imem_addr, 32'h0040_0004);
    chk("ack_valid", 32'(instr_valid), 32'd0);

    // decode stalls 5 cycles
    for (int i = 0; i < 5; i++) begin
      nxt(); imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; settle();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'h8C09_0010);
      chk("stall_pcld", 32'(pc_ld), 32'd0);
      chk("stall_count", instr_count, 32'd1);
    end
    nxt(); instr_ready = 1'b1; settle();
    chk("ready_pcld", 32'(pc_ld), 32'd1);
    chk("ready_pc_next", pc_next, 32'h0040_0008);
    nxt(); imem_ack = 1'b1; imem_rdata = 32'h1000_0003; settle();
    chk("req2_addr", imem_addr, 32'h0040_0008);
    chk("count2", instr_count, 32'd2);

    // branch in DELIVER with ready high
    nxt(); imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h0040_0100; settle();
    chk("br_valid", 32'(instr_valid), 32'd0);
    chk("br_pcld", 32'(pc_ld), 32'd1);
    chk("br_pc_next", pc_next, 32'h0040_0100);
    chk("br_req", 32'(imem_req), 32'd0);
    nxt(); branch_taken = 1'b0; settle();
    chk("br_req_addr", imem_addr, 32'h0040_0100);
    chk("br_req_on", 32'(imem_req), 32'd1);
    chk("br_count", instr_count, 32'd2);
    chk("br_valid2", 32'(instr_valid), 32'd0);

    // branch in REQ to the top word, then wrap on accept
    nxt(); imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; settle();
    chk("br2_req", 32'(imem_req), 32'd0);
    chk("br2_pc_next", pc_next, 32'hFFFF_FFFC);
    nxt(); branch_taken = 1'b0; imem_rdata = 32'h0000_000C; settle();
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("top_req", 32'(imem_req), 32'd1);
    nxt(); imem_ack = 1'b0; settle();
    chk("top_instr", instr, 32'h0000_000C);
    chk("wrap_pc_next", pc_next, 32'h0000_0000);
    chk("wrap_pcld", 32'(pc_ld), 32'd1);
    nxt(); settle();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("count3", instr_count, 32'd3);

    // misaligned redirect
    nxt(); branch_taken = 1'b1; branch_target = 32'h0040_0102; settle();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_pcld", 32'(pc_ld), 32'd0);
    nxt(); branch_taken = 1'b0; settle();
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_refetch", imem_addr, 32'h0000_0000);
    chk("mis_req", 32'(imem_req), 32'd1);
    nxt(); rst = 1'b1; settle();
    chk("err_sticky", 32'(fetch_err), 32'd1);
    nxt(); settle();
    chk("err_clr", 32'(fetch_err), 32'd0);
`else
    chk("mis_pcld", 32'(pc_ld), 32'd1);
    chk("mis_pc_next", pc_next, 32'h0040_0102);
    nxt(); branch_taken = 1'b0; settle();
    chk("mis_err", 32'(fetch_err), 32'd0);
    chk("mis_addr", imem_addr, 32'h0040_0102);
    nxt(); rst = 1'b1; settle();
    nxt(); settle();
`endif
    // mid-run reset clears registered state and reloads the vector
    chk("rst2_count", instr_count, 32'd0);
    chk("rst2_instr", instr, 32'd0);
    chk("rst2_pcld", 32'(pc_ld), 32'd1);
    chk("rst2_pc_next", pc_next, 32'h0040_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
